control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPC_W, 5, opcode width.
REQ-002 SHALL have parameter ALU_W, 5, alu_op width.
REQ-003 SHALL have parameter WAIT_MAX, 15, max memory wait cycles before error (1..255).
REQ-004 SHALL have ports: clk in 1, single clock; clr in 1, synchronous active-low reset (one clock; reset is synchronous and active-low).
REQ-005 SHALL have inputs: run 1 (permit fetch), opcode OPC_W (IR[31:27]), con_ff 1 (branch condition), mem_ready 1 (memory handshake).
REQ-006 SHALL have outputs, 1 bit each: pc_out, pc_en, pc_inc, mar_en, mdr_en, mdr_out, read, write, ir_en, gra, grb, grc, r_in, r_out, ba_out, c_out, y_en, z_lo_en, z_hi_en, z_lo_out, z_hi_out, hi_en, lo_en, hi_out, lo_out, con_in.
REQ-007 SHALL have outputs alu_op ALU_W, step 4 (current T-step), busy 1, halted 1, illegal 1 (one-cycle pulse), mem_err 1 (sticky).

Function
REQ-008 Control outputs SHALL be Moore-decoded from state only. Asserted signals per step are listed; all others are 0.
REQ-009 States SHALL be IDLE, T0..T7, HALTED. step SHALL read 0 in IDLE/HALTED, else the T index.
REQ-010 IDLE->T0 SHALL occur when run=1. After the last step of an instruction, the next state SHALL be T0 if run=1, else IDLE.
REQ-011 Fetch SHALL be: T0 pc_out,mar_en,pc_inc,pc_en; T1 read,mdr_en; T2 mdr_out,ir_en. opcode SHALL be sampled at the end of T2.
REQ-012 Read/write steps (fetch T1, LD T6, ST T7) SHALL hold all signals until mem_ready=1. They SHALL advance on the edge where mem_ready=1.
REQ-013 After WAIT_MAX consecutive not-ready cycles: mem_err SHALL be set, the instruction SHALL be abandoned, and the next state SHALL be IDLE.
REQ-014 ALU3 (add..rol, 00011-01010): T3 grb,r_out,y_en; T4 grc,r_out,alu_op=opcode,z_lo_en; T5 z_lo_out,gra,r_in.
REQ-015 ALUI (addi/andi/ori): T3 grb,r_out,y_en; T4 c_out,alu_op=opcode,z_lo_en; T5 z_lo_out,gra,r_in.
REQ-016 LD/LDI: T3 grb,ba_out,y_en; T4 c_out,alu_op=ADD,z_lo_en. LDI: T5 z_lo_out,gra,r_in (end). LD: T5 z_lo_out,mar_en; T6 read,mdr_en; T7 mdr_out,gra,r_in.
REQ-017 ST: T3..T5 as LD; T6 gra,r_out,mdr_en; T7 write.
REQ-018 MUL/DIV: T3 gra,r_out,y_en; T4 grb,r_out,alu_op=opcode,z_lo_en,z_hi_en; T5 z_lo_out,lo_en; T6 z_hi_out,hi_en.
REQ-019 MFHI/MFLO: T3 hi_out (or lo_out),gra,r_in.
REQ-020 BR: T3 gra,r_out,con_in; T4 pc_out,y_en; T5 c_out,alu_op=ADD,z_lo_en; T6 z_lo_out, plus pc_en only if con_ff=1 in T6.
REQ-021 NOP SHALL end at T2. HALT SHALL go to HALTED, halted=1, and remain there until reset.
REQ-022 Any undefined opcode SHALL pulse illegal during T3 (no other outputs) and then follow REQ-010.
REQ-023 busy SHALL be 1 in T0..T7 and 0 in IDLE/HALTED.
REQ-024 run deasserted mid-instruction SHALL be ignored until the instruction boundary.

Reset
REQ-025 clr=0 at a clk edge SHALL force IDLE, clear the wait counter, and set halted=0, mem_err=0, illegal=0. This SHALL take priority over everything, including mid-wait and HALTED.
REQ-026 While clr=0, all outputs SHALL be 0 and alu_op SHALL be 0.

Configuration
REQ-027 With MUL_DIV_EN defined, REQ-018 sequences SHALL be generated.
REQ-028 Without MUL_DIV_EN, mul/div SHALL be treated as illegal per REQ-022, and z_hi_en, hi_en, lo_en SHALL be constant 0. MFHI/MFLO SHALL be unaffected.

Structure
REQ-029 Package ctrl_seq_pkg SHALL hold opcode constants, state encoding, ALU ADD code and opcode-class decode function.
REQ-030 Sub-module ctrl_seq_wait SHALL implement the saturating wait counter and timeout flag.

Verification
REQ-031 Reset then run=1, opcode=NOP, mem_ready=1 -> step 0,1,2 loops. pc_out,mar_en in T0; busy=1.
REQ-032 Fetch with mem_ready low 3 cycles -> T1 held 4 cycles with read=1, mdr_en=1. ir_en at the following step.
REQ-033 Opcode 00011 (add) -> T4 alu_op=00011, grc=1; T5 gra=1, r_in=1; back to T0.
REQ-034 BR with con_ff=0 -> T6 z_lo_out=1, pc_en=0. With con_ff=1 -> pc_en=1.
REQ-035 LD with mem_ready stuck 0, WAIT_MAX=15 -> mem_err=1 after 15 cycles of T6, state IDLE. clr=0 -> mem_err=0.
REQ-036 Opcode 01110 without MUL_DIV_EN -> illegal=1 for one cycle at T3, hi_en never 1. HALT -> halted=1 until clr=0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg -- shared definitions for control_sequencer.
//   Opcode map, FSM state encoding, opcode-class decode and the packed
//   control-word layout driven by the sequencer each T-step.
//   MUL_DIV_EN: when defined, mul/div decode to their own class; otherwise
//   they fall into the illegal class.
//
// Opcode map (IR[31:27]):
//   00000 ld    00001 ldi   00010 st
//   00011..01010 three-register ALU ops (add .. rol)
//   01011 addi  01100 andi  01101 ori
//   01110 mul   01111 div
//   10010 br    10111 mfhi  11000 mflo
//   11010 nop   11011 halt
//   every other code is undefined.
package ctrl_seq_pkg;

  typedef logic [4:0] opc_t;

  localparam opc_t OP_LD   = 5'b00000;
  localparam opc_t OP_LDI  = 5'b00001;
  localparam opc_t OP_ST   = 5'b00010;
  localparam opc_t OP_ADD  = 5'b00011;
  localparam opc_t OP_ROL  = 5'b01010;
  localparam opc_t OP_ADDI = 5'b01011;
  localparam opc_t OP_ANDI = 5'b01100;
  localparam opc_t OP_ORI  = 5'b01101;
  localparam opc_t OP_MUL  = 5'b01110;
  localparam opc_t OP_DIV  = 5'b01111;
  localparam opc_t OP_BR   = 5'b10010;
  localparam opc_t OP_MFHI = 5'b10111;
  localparam opc_t OP_MFLO = 5'b11000;
  localparam opc_t OP_NOP  = 5'b11010;
  localparam opc_t OP_HALT = 5'b11011;

  // Address arithmetic (ld/ldi/st/br) reuses the add encoding on the ALU.
  localparam opc_t ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_HALTED
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU3, CL_ALUI, CL_LD, CL_LDI, CL_ST, CL_MULDIV,
    CL_MFHI, CL_MFLO, CL_BR, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic pc_en;
    logic pc_inc;
    logic mar_en;
    logic mdr_en;
    logic mdr_out;
    logic read;
    logic write;
    logic ir_en;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic y_en;
    logic z_lo_en;
    logic z_hi_en;
    logic z_lo_out;
    logic z_hi_out;
    logic hi_en;
    logic lo_en;
    logic hi_out;
    logic lo_out;
    logic con_in;
  } ctrl_t;

  function automatic op_class_t op_class(input opc_t op);
    op_class_t c;
    c = CL_ILLEGAL;
    if (op inside {[OP_ADD:OP_ROL]}) begin
      c = CL_ALU3;
    end else begin
      case (op)
        OP_LD:   c = CL_LD;
        OP_LDI:  c = CL_LDI;
        OP_ST:   c = CL_ST;
        OP_ADDI: c = CL_ALUI;
        OP_ANDI: c = CL_ALUI;
        OP_ORI:  c = CL_ALUI;
`ifdef MUL_DIV_EN
        OP_MUL:  c = CL_MULDIV;
        OP_DIV:  c = CL_MULDIV;
`endif
        OP_BR:   c = CL_BR;
        OP_MFHI: c = CL_MFHI;
        OP_MFLO: c = CL_MFLO;
        OP_NOP:  c = CL_NOP;
        OP_HALT: c = CL_HALT;
        default: c = CL_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ctrl_seq_wait.sv
// ctrl_seq_wait -- memory handshake wait counter.
//   Counts consecutive not-ready cycles while a memory step is active and
//   flags the cycle on which the WAIT_MAX-th not-ready cycle occurs.
// Ports:
//   clk        clock
//   clr        synchronous active-low reset
//   active     sequencer is in a read/write step
//   mem_ready  memory handshake
//   timeout    this cycle is the WAIT_MAX-th consecutive not-ready cycle
module ctrl_seq_wait #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active || mem_ready) begin
      cnt_d = '0;
    end else if (cnt_q != WAIT_LIM) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // cnt_q holds the not-ready cycles already seen, so the current cycle is
  // number cnt_q+1.
  assign timeout = active && !mem_ready && (cnt_q == WAIT_LIM - 8'd1);

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- hard-wired T-step control unit.
//   IDLE -> T0..T7 per instruction class -> T0/IDLE; HALT parks in HALTED.
//   Control outputs are decoded from the state register and the latched
//   opcode; the only input feeding an output is con_ff into pc_en at BR T6.
//   MUL_DIV_EN: when defined, mul/div get their T3..T6 sequence; otherwise
//   they are illegal and z_hi_en/hi_en/lo_en stay 0.
// Ports:
//   clk, clr              clock, synchronous active-low reset
//   run                   permit fetch at an instruction boundary
//   opcode                IR[31:27], sampled at the end of T2
//   con_ff                branch condition
//   mem_ready             memory handshake for fetch T1, LD T6, ST T7
//   pc_out..con_in        datapath control strobes
//   alu_op                ALU operation select
//   step                  current T index (0 in IDLE/HALTED)
//   busy, halted          status
//   illegal               one-cycle pulse at T3 of an undefined opcode
//   mem_err               sticky memory timeout flag
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned OPC_W    = 5,
  parameter int unsigned ALU_W    = 5,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             con_ff,
  input  logic             mem_ready,
  output logic             pc_out,
  output logic             pc_en,
  output logic             pc_inc,
  output logic             mar_en,
  output logic             mdr_en,
  output logic             mdr_out,
  output logic             read,
  output logic             write,
  output logic             ir_en,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             r_in,
  output logic             r_out,
  output logic             ba_out,
  output logic             c_out,
  output logic             y_en,
  output logic             z_lo_en,
  output logic             z_hi_en,
  output logic             z_lo_out,
  output logic             z_hi_out,
  output logic             hi_en,
  output logic             lo_en,
  output logic             hi_out,
  output logic             lo_out,
  output logic             con_in,
  output logic [ALU_W-1:0] alu_op,
  output logic [3:0]       step,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err
);

  state_t    state_q, state_d;
  opc_t      ir_op_q, ir_op_d;
  logic      mem_err_q, mem_err_d;
  op_class_t cls, fetch_cls;
  logic      mem_step, timeout, instr_end;
  ctrl_t     ctl;
  opc_t      alu_sel;
  logic      illegal_v;

  assign cls       = op_class(ir_op_q);
  assign fetch_cls = op_class(opc_t'(opcode));

  assign mem_step = (state_q == ST_T1) ||
                    ((state_q == ST_T6) && (cls == CL_LD)) ||
                    ((state_q == ST_T7) && (cls == CL_ST));

  ctrl_seq_wait #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk       (clk),
    .clr       (clr),
    .active    (mem_step),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // Next state. T2 branches on the live opcode because it is the cycle that
  // latches it; later steps branch on the latched copy.
  always_comb begin
    state_d   = state_q;
    ir_op_d   = ir_op_q;
    mem_err_d = mem_err_q;
    instr_end = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (mem_ready) state_d = ST_T2;
      ST_T2: begin
        ir_op_d = opc_t'(opcode);
        case (fetch_cls)
          CL_NOP:  instr_end = 1'b1;
          CL_HALT: state_d = ST_HALTED;
          default: state_d = ST_T3;
        endcase
      end
      ST_T3: begin
        if (cls inside {CL_MFHI, CL_MFLO, CL_ILLEGAL}) instr_end = 1'b1;
        else state_d = ST_T4;
      end
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        if (cls inside {CL_ALU3, CL_ALUI, CL_LDI}) instr_end = 1'b1;
        else state_d = ST_T6;
      end
      ST_T6: begin
        if (cls == CL_LD) begin
          if (mem_ready) state_d = ST_T7;
        end else if (cls == CL_ST) begin
          state_d = ST_T7;
        end else begin
          instr_end = 1'b1;
        end
      end
      ST_T7: begin
        if (cls != CL_ST || mem_ready) instr_end = 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    if (instr_end) state_d = run ? ST_T0 : ST_IDLE;
    if (timeout) begin
      state_d   = ST_IDLE;
      mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      ir_op_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_op_q   <= ir_op_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Control decode; everything is forced to 0 while clr is low.
  always_comb begin
    ctl       = '0;
    alu_sel   = '0;
    illegal_v = 1'b0;
    if (clr) begin
      case (state_q)
        ST_T0: begin
          ctl.pc_out = 1'b1; ctl.mar_en = 1'b1; ctl.pc_inc = 1'b1; ctl.pc_en = 1'b1;
        end
        ST_T1: begin
          ctl.read = 1'b1; ctl.mdr_en = 1'b1;
        end
        ST_T2: begin
          ctl.mdr_out = 1'b1; ctl.ir_en = 1'b1;
        end
        ST_T3: begin
          case (cls)
            CL_ALU3, CL_ALUI: begin
              ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1;
            end
            CL_LD, CL_LDI, CL_ST: begin
              ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_en = 1'b1;
            end
`ifdef MUL_DIV_EN
            CL_MULDIV: begin
              ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_en = 1'b1;
            end
`endif
            CL_MFHI: begin
              ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
            end
            CL_MFLO: begin
              ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
            end
            CL_BR: begin
              ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
            end
            CL_ILLEGAL: illegal_v = 1'b1;
            default: ;
          endcase
        end
        ST_T4: begin
          case (cls)
            CL_ALU3: begin
              ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_lo_en = 1'b1; alu_sel = ir_op_q;
            end
            CL_ALUI: begin
              ctl.c_out = 1'b1; ctl.z_lo_en = 1'b1; alu_sel = ir_op_q;
            end
            CL_LD, CL_LDI, CL_ST: begin
              ctl.c_out = 1'b1; ctl.z_lo_en = 1'b1; alu_sel = ALU_ADD;
            end
`ifdef MUL_DIV_EN
            CL_MULDIV: begin
              ctl.grb = 1'b1; ctl.r_out = 1'b1; alu_sel = ir_op_q;
              ctl.z_lo_en = 1'b1; ctl.z_hi_en = 1'b1;
            end
`endif
            CL_BR: begin
              ctl.pc_out = 1'b1; ctl.y_en = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T5: begin
          case (cls)
            CL_ALU3, CL_ALUI, CL_LDI: begin
              ctl.z_lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
            end
            CL_LD, CL_ST: begin
              ctl.z_lo_out = 1'b1; ctl.mar_en = 1'b1;
            end
`ifdef MUL_DIV_EN
            CL_MULDIV: begin
              ctl.z_lo_out = 1'b1; ctl.lo_en = 1'b1;
            end
`endif
            CL_BR: begin
              ctl.c_out = 1'b1; ctl.z_lo_en = 1'b1; alu_sel = ALU_ADD;
            end
            default: ;
          endcase
        end
        ST_T6: begin
          case (cls)
            CL_LD: begin
              ctl.read = 1'b1; ctl.mdr_en = 1'b1;
            end
            CL_ST: begin
              ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_en = 1'b1;
            end
`ifdef MUL_DIV_EN
            CL_MULDIV: begin
              ctl.z_hi_out = 1'b1; ctl.hi_en = 1'b1;
            end
`endif
            CL_BR: begin
              ctl.z_lo_out = 1'b1; ctl.pc_en = con_ff;
            end
            default: ;
          endcase
        end
        ST_T7: begin
          case (cls)
            CL_LD: begin
              ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
            end
            CL_ST: ctl.write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign pc_out   = ctl.pc_out;
  assign pc_en    = ctl.pc_en;
  assign pc_inc   = ctl.pc_inc;
  assign mar_en   = ctl.mar_en;
  assign mdr_en   = ctl.mdr_en;
  assign mdr_out  = ctl.mdr_out;
  assign read     = ctl.read;
  assign write    = ctl.write;
  assign ir_en    = ctl.ir_en;
  assign gra      = ctl.gra;
  assign grb      = ctl.grb;
  assign grc      = ctl.grc;
  assign r_in     = ctl.r_in;
  assign r_out    = ctl.r_out;
  assign ba_out   = ctl.ba_out;
  assign c_out    = ctl.c_out;
  assign y_en     = ctl.y_en;
  assign z_lo_en  = ctl.z_lo_en;
  assign z_hi_en  = ctl.z_hi_en;
  assign z_lo_out = ctl.z_lo_out;
  assign z_hi_out = ctl.z_hi_out;
  assign hi_en    = ctl.hi_en;
  assign lo_en    = ctl.lo_en;
  assign hi_out   = ctl.hi_out;
  assign lo_out   = ctl.lo_out;
  assign con_in   = ctl.con_in;

  assign alu_op  = ALU_W'(alu_sel);
  assign illegal = illegal_v;
  assign busy    = clr && (state_q inside {[ST_T0:ST_T7]});
  assign step    = busy ? 4'(state_q - ST_T0) : 4'd0;
  assign halted  = clr && (state_q == ST_HALTED);
  assign mem_err = clr && mem_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- scoreboard bench for control_sequencer.
//   Each driven cycle pushes the expected step/control/flag vector; a
//   monitor pops it shortly after the falling edge and compares.
module tb_control_sequencer;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] JUNK    = 5'b11111;

  // Control word bit order matches ctl_vec below (pc_out is the MSB).
  localparam logic [25:0] M_PC_OUT   = 26'b1 << 25;
  localparam logic [25:0] M_PC_EN    = 26'b1 << 24;
  localparam logic [25:0] M_PC_INC   = 26'b1 << 23;
  localparam logic [25:0] M_MAR_EN   = 26'b1 << 22;
  localparam logic [25:0] M_MDR_EN   = 26'b1 << 21;
  localparam logic [25:0] M_MDR_OUT  = 26'b1 << 20;
  localparam logic [25:0] M_READ     = 26'b1 << 19;
  localparam logic [25:0] M_WRITE    = 26'b1 << 18;
  localparam logic [25:0] M_IR_EN    = 26'b1 << 17;
  localparam logic [25:0] M_GRA      = 26'b1 << 16;
  localparam logic [25:0] M_GRB      = 26'b1 << 15;
  localparam logic [25:0] M_GRC      = 26'b1 << 14;
  localparam logic [25:0] M_R_IN     = 26'b1 << 13;
  localparam logic [25:0] M_R_OUT    = 26'b1 << 12;
  localparam logic [25:0] M_BA_OUT   = 26'b1 << 11;
  localparam logic [25:0] M_C_OUT    = 26'b1 << 10;
  localparam logic [25:0] M_Y_EN     = 26'b1 << 9;
  localparam logic [25:0] M_Z_LO_EN  = 26'b1 << 8;
  localparam logic [25:0] M_Z_HI_EN  = 26'b1 << 7;
  localparam logic [25:0] M_Z_LO_OUT = 26'b1 << 6;
  localparam logic [25:0] M_Z_HI_OUT = 26'b1 << 5;
  localparam logic [25:0] M_HI_EN    = 26'b1 << 4;
  localparam logic [25:0] M_LO_EN    = 26'b1 << 3;
  localparam logic [25:0] M_HI_OUT   = 26'b1 << 2;
  localparam logic [25:0] M_LO_OUT   = 26'b1 << 1;
  localparam logic [25:0] M_CON_IN   = 26'b1 << 0;

  localparam logic [25:0] M_F0 = M_PC_OUT | M_MAR_EN | M_PC_INC | M_PC_EN;
  localparam logic [25:0] M_F1 = M_READ | M_MDR_EN;
  localparam logic [25:0] M_F2 = M_MDR_OUT | M_IR_EN;
  localparam logic [25:0] M_NONE = 26'b0;

  // Flags: {busy, halted, illegal, mem_err}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_B    = 4'b1000;
  localparam logic [3:0] F_HALT = 4'b0100;
  localparam logic [3:0] F_ILL  = 4'b1010;
  localparam logic [3:0] F_ERR  = 4'b0001;

  logic clk = 1'b0;
  logic clr = 1'b0, run = 1'b0, con_ff = 1'b0, mem_ready = 1'b0;
  logic [4:0] opcode = 5'b0;
  logic pc_out, pc_en, pc_inc, mar_en, mdr_en, mdr_out, read, write, ir_en;
  logic gra, grb, grc, r_in, r_out, ba_out, c_out, y_en, z_lo_en, z_hi_en;
  logic z_lo_out, z_hi_out, hi_en, lo_en, hi_out, lo_out, con_in;
  logic [4:0] alu_op;
  logic [3:0] step;
  logic busy, halted, illegal, mem_err;
  logic [25:0] ctl_vec;

  always #5 clk = ~clk;

  control_sequencer #(.OPC_W(5), .ALU_W(5), .WAIT_MAX(15)) dut (
    .clk(clk), .clr(clr), .run(run), .opcode(opcode), .con_ff(con_ff),
    .mem_ready(mem_ready),
    .pc_out(pc_out), .pc_en(pc_en), .pc_inc(pc_inc), .mar_en(mar_en),
    .mdr_en(mdr_en), .mdr_out(mdr_out), .read(read), .write(write),
    .ir_en(ir_en), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
    .r_out(r_out), .ba_out(ba_out), .c_out(c_out), .y_en(y_en),
    .z_lo_en(z_lo_en), .z_hi_en(z_hi_en), .z_lo_out(z_lo_out),
    .z_hi_out(z_hi_out), .hi_en(hi_en), .lo_en(lo_en), .hi_out(hi_out),
    .lo_out(lo_out), .con_in(con_in), .alu_op(alu_op), .step(step),
    .busy(busy), .halted(halted), .illegal(illegal), .mem_err(mem_err)
  );

  assign ctl_vec = {pc_out, pc_en, pc_inc, mar_en, mdr_en, mdr_out, read,
                    write, ir_en, gra, grb, grc, r_in, r_out, ba_out, c_out,
                    y_en, z_lo_en, z_hi_en, z_lo_out, z_hi_out, hi_en, lo_en,
                    hi_out, lo_out, con_in};

  typedef struct {
    string       tag;
    logic [3:0]  step;
    logic [25:0] ctl;
    logic [4:0]  alu;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Monitor: outputs are stable 2 time units after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val({e.tag, " step"},  32'(step), 32'(e.step));
        check_val({e.tag, " ctl"},   32'(ctl_vec), 32'(e.ctl));
        check_val({e.tag, " alu"},   32'(alu_op), 32'(e.alu));
        check_val({e.tag, " flags"}, 32'({busy, halted, illegal, mem_err}), 32'(e.flg));
      end
    end
  end

  task automatic vec(input string t, input logic c, input logic r,
                     input logic [4:0] op, input logic cf, input logic rdy,
                     input logic [3:0] s, input logic [25:0] m,
                     input logic [4:0] a, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    clr = c; run = r; opcode = op; con_ff = cf; mem_ready = rdy;
    e.tag = t; e.step = s; e.ctl = m; e.alu = a; e.flg = f;
    sb.push_back(e);
  endtask

  task automatic xc(input string t, input logic r, input logic [4:0] op,
                    input logic cf, input logic rdy, input logic [3:0] s,
                    input logic [25:0] m, input logic [4:0] a,
                    input logic [3:0] f);
    vec(t, 1'b1, r, op, cf, rdy, s, m, a, f);
  endtask

  task automatic fetch(input string t, input logic [4:0] op, input logic r);
    xc({t, " T0"}, r, JUNK, 1'b0, 1'b1, 4'd0, M_F0, 5'd0, F_B);
    xc({t, " T1"}, r, JUNK, 1'b0, 1'b1, 4'd1, M_F1, 5'd0, F_B);
    xc({t, " T2"}, r, op,   1'b0, 1'b1, 4'd2, M_F2, 5'd0, F_B);
  endtask

  // LD/ST/LDI share T3..T4; T5 differs only for LDI.
  task automatic addr_steps(input string t);
    xc({t, " T3"}, 1'b0, JUNK, 1'b0, 1'b1, 4'd3, M_GRB | M_BA_OUT | M_Y_EN, 5'd0, F_B);
    xc({t, " T4"}, 1'b0, JUNK, 1'b0, 1'b1, 4'd4, M_C_OUT | M_Z_LO_EN, OP_ADD, F_B);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset: outputs zero while clr is low even with run high.
    vec("rst0", 1'b0, 1'b0, JUNK, 1'b0, 1'b0, 4'd0, M_NONE, 5'd0, F_NONE);
    vec("rst1", 1'b0, 1'b1, JUNK, 1'b1, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);
    xc("idle", 1'b1, OP_NOP, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);

    // NOP loop.
    fetch("nop1", OP_NOP, 1'b1);
    fetch("nop2", OP_NOP, 1'b1);

    // Fetch with three not-ready cycles, then drop to IDLE.
    xc("wt T0", 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_F0, 5'd0, F_B);
    for (int i = 0; i < 3; i++)
      xc("wt T1 hold", 1'b1, JUNK, 1'b0, 1'b0, 4'd1, M_F1, 5'd0, F_B);
    xc("wt T1 go", 1'b1, JUNK, 1'b0, 1'b1, 4'd1, M_F1, 5'd0, F_B);
    xc("wt T2", 1'b0, OP_NOP, 1'b0, 1'b1, 4'd2, M_F2, 5'd0, F_B);
    xc("wt idle", 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);

    // WAIT_MAX-1 not-ready cycles must not time out.
    xc("edge T0", 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_F0, 5'd0, F_B);
    for (int i = 0; i < 14; i++)
      xc("edge T1 hold", 1'b1, JUNK, 1'b0, 1'b0, 4'd1, M_F1, 5'd0, F_B);
    xc("edge T1 go", 1'b1, JUNK, 1'b0, 1'b1, 4'd1, M_F1, 5'd0, F_B);
    xc("edge T2", 1'b1, OP_NOP, 1'b0, 1'b1, 4'd2, M_F2, 5'd0, F_B);

    // ADD, run low mid-instruction is ignored.
    fetch("add", OP_ADD, 1'b0);
    xc("add T3", 1'b0, JUNK, 1'b0, 1'b1, 4'd3, M_GRB | M_R_OUT | M_Y_EN, 5'd0, F_B);
    xc("add T4", 1'b0, JUNK, 1'b0, 1'b1, 4'd4, M_GRC | M_R_OUT | M_Z_LO_EN, OP_ADD, F_B);
    xc("add T5", 1'b1, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_GRA | M_R_IN, 5'd0, F_B);

    // ADDI.
    fetch("addi", OP_ADDI, 1'b1);
    xc("addi T3", 1'b1, JUNK, 1'b0, 1'b1, 4'd3, M_GRB | M_R_OUT | M_Y_EN, 5'd0, F_B);
    xc("addi T4", 1'b1, JUNK, 1'b0, 1'b1, 4'd4, M_C_OUT | M_Z_LO_EN, OP_ADDI, F_B);
    xc("addi T5", 1'b1, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_GRA | M_R_IN, 5'd0, F_B);

    // BR not taken (con_ff high before T6 must not matter), then taken.
    for (int k = 0; k < 2; k++) begin
      fetch("br", OP_BR, 1'b1);
      xc("br T3", 1'b1, JUNK, 1'b1, 1'b1, 4'd3, M_GRA | M_R_OUT | M_CON_IN, 5'd0, F_B);
      xc("br T4", 1'b1, JUNK, 1'b1, 1'b1, 4'd4, M_PC_OUT | M_Y_EN, 5'd0, F_B);
      xc("br T5", 1'b1, JUNK, 1'b1, 1'b1, 4'd5, M_C_OUT | M_Z_LO_EN, OP_ADD, F_B);
      if (k == 0)
        xc("br T6 nt", 1'b1, JUNK, 1'b0, 1'b1, 4'd6, M_Z_LO_OUT, 5'd0, F_B);
      else
        xc("br T6 tk", 1'b1, JUNK, 1'b1, 1'b1, 4'd6, M_Z_LO_OUT | M_PC_EN, 5'd0, F_B);
    end

    // LDI.
    fetch("ldi", OP_LDI, 1'b1);
    addr_steps("ldi");
    xc("ldi T5", 1'b1, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_GRA | M_R_IN, 5'd0, F_B);

    // LD with immediate ready.
    fetch("ld", OP_LD, 1'b1);
    addr_steps("ld");
    xc("ld T5", 1'b1, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_MAR_EN, 5'd0, F_B);
    xc("ld T6", 1'b1, JUNK, 1'b0, 1'b1, 4'd6, M_READ | M_MDR_EN, 5'd0, F_B);
    xc("ld T7", 1'b1, JUNK, 1'b0, 1'b1, 4'd7, M_MDR_OUT | M_GRA | M_R_IN, 5'd0, F_B);

    // ST: T6 ignores mem_ready, T7 waits one cycle.
    fetch("st", OP_ST, 1'b1);
    addr_steps("st");
    xc("st T5", 1'b1, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_MAR_EN, 5'd0, F_B);
    xc("st T6", 1'b1, JUNK, 1'b0, 1'b0, 4'd6, M_GRA | M_R_OUT | M_MDR_EN, 5'd0, F_B);
    xc("st T7 hold", 1'b1, JUNK, 1'b0, 1'b0, 4'd7, M_WRITE, 5'd0, F_B);
    xc("st T7 go", 1'b1, JUNK, 1'b0, 1'b1, 4'd7, M_WRITE, 5'd0, F_B);

    // MFHI / MFLO.
    fetch("mfhi", OP_MFHI, 1'b1);
    xc("mfhi T3", 1'b1, JUNK, 1'b0, 1'b1, 4'd3, M_HI_OUT | M_GRA | M_R_IN, 5'd0, F_B);
    fetch("mflo", OP_MFLO, 1'b1);
    xc("mflo T3", 1'b1, JUNK, 1'b0, 1'b1, 4'd3, M_LO_OUT | M_GRA | M_R_IN, 5'd0, F_B);

    // MUL.
    fetch("mul", OP_MUL, 1'b1);
`ifdef MUL_DIV_EN
    xc("mul T3", 1'b1, JUNK, 1'b0, 1'b1, 4'd3, M_GRA | M_R_OUT | M_Y_EN, 5'd0, F_B);
    xc("mul T4", 1'b1, JUNK, 1'b0, 1'b1, 4'd4, M_GRB | M_R_OUT | M_Z_LO_EN | M_Z_HI_EN, OP_MUL, F_B);
    xc("mul T5", 1'b1, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_LO_EN, 5'd0, F_B);
    xc("mul T6", 1'b1, JUNK, 1'b0, 1'b1, 4'd6, M_Z_HI_OUT | M_HI_EN, 5'd0, F_B);
`else
    xc("mul T3 ill", 1'b1, JUNK, 1'b0, 1'b1, 4'd3, M_NONE, 5'd0, F_ILL);
`endif

    // Undefined opcode.
    fetch("undef", JUNK, 1'b1);
    xc("undef T3", 1'b1, JUNK, 1'b0, 1'b1, 4'd3, M_NONE, 5'd0, F_ILL);

    // LD timeout: 15 not-ready T6 cycles, then IDLE with sticky mem_err.
    fetch("ldto", OP_LD, 1'b0);
    addr_steps("ldto");
    xc("ldto T5", 1'b0, JUNK, 1'b0, 1'b1, 4'd5, M_Z_LO_OUT | M_MAR_EN, 5'd0, F_B);
    for (int i = 0; i < 15; i++)
      xc("ldto T6 hold", 1'b0, JUNK, 1'b0, 1'b0, 4'd6, M_READ | M_MDR_EN, 5'd0, F_B);
    xc("ldto idle1", 1'b0, JUNK, 1'b0, 1'b0, 4'd0, M_NONE, 5'd0, F_ERR);
    xc("ldto idle2", 1'b0, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_ERR);
    vec("ldto rst", 1'b0, 1'b0, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);
    xc("ldto clr", 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);

    // Reset in the middle of a fetch wait.
    xc("mw T0", 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_F0, 5'd0, F_B);
    xc("mw T1", 1'b1, JUNK, 1'b0, 1'b0, 4'd1, M_F1, 5'd0, F_B);
    vec("mw rst", 1'b0, 1'b1, JUNK, 1'b0, 1'b0, 4'd0, M_NONE, 5'd0, F_NONE);
    xc("mw idle", 1'b0, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);
    xc("mw go", 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);

    // HALT parks until reset, regardless of run.
    fetch("halt", OP_HALT, 1'b1);
    for (int i = 0; i < 3; i++)
      xc("halted", 1'b1, JUNK, 1'b1, 1'b1, 4'd0, M_NONE, 5'd0, F_HALT);
    vec("halt rst", 1'b0, 1'b1, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);
    xc("halt idle", 1'b0, JUNK, 1'b0, 1'b1, 4'd0, M_NONE, 5'd0, F_NONE);

    repeat (2) @(negedge clk);
    #3;
    check_val("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
